// File: rtl/channel_reduce_pkg.sv
// Shared types and helpers for channel reduction blocks.
// Operators, FSM states and per-operator identity values.
package channel_reduce_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_MAX = 2'd1,
        OP_MIN = 2'd2,
        OP_XOR = 2'd3
    } reduce_op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    localparam int ID_W = 256;

    // Returned value is ID_W wide; callers size-cast it down to their width.
    function automatic logic [ID_W-1:0] identity(
        input reduce_op_t op,
        input int         width
    );
        logic [ID_W-1:0] v;
        v = '0;
        if (op == OP_MIN) begin
            for (int i = 0; i < ID_W; i++) begin
                if (i < width) v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/channel_reduce_alu.sv
// Combinational fold operator shared by reduce blocks.
// carry is the unsigned carry-out of the add; zero for other operators.
module reduce_alu
    import channel_reduce_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             carry
);

    logic [WIDTH:0] sum;

    assign sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        y     = '0;
        carry = 1'b0;
        unique case (reduce_op_t'(op))
            OP_ADD: begin
                y     = sum[WIDTH-1:0];
                carry = sum[WIDTH];
            end
            OP_MAX: y = (a > b) ? a : b;
            OP_MIN: y = (a < b) ? a : b;
            OP_XOR: y = a ^ b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/channel_reduce_n.sv
// Pops a runtime-sized batch from a channel, folds it, pushes one result.
// Re-arms after each result handshake.
module channel_reduce_n
    import channel_reduce_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MAX_COUNT = 16,
    parameter int CW        = $clog2(MAX_COUNT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CW-1:0]    cfg_count,
    input  logic [1:0]       cfg_op,
    output logic             busy,
    output logic             valid,
    output logic             result_ovf,
    input  logic [WIDTH-1:0] in_out_data,
    input  logic             in_read_ready,
    input  logic             in_write_ready,
    output logic             in_read_valid,
    output logic [WIDTH-1:0] in_in_data,
    output logic             in_write_valid,
    output logic             in_rst,
    output logic [WIDTH-1:0] out_in_data,
    output logic             out_write_valid,
    input  logic             out_write_ready,
    input  logic [WIDTH-1:0] out_out_data,
    input  logic             out_read_ready,
    output logic             out_read_valid,
    output logic             out_rst
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_COUNT);

    state_t           state_q, state_d;
    reduce_op_t       op_q, op_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic             valid_q;

    logic [CW-1:0]    count_clamp;
    logic [CW-1:0]    cnt_inc;
    logic [WIDTH-1:0] ident;
    logic [WIDTH-1:0] alu_y;
    logic             alu_carry;
    logic             unused_ok;

    assign count_clamp = (cfg_count > MAX_CNT) ? MAX_CNT : cfg_count;
    assign cnt_inc     = cnt_q + 1'b1;
    assign ident       = WIDTH'(identity(reduce_op_t'(cfg_op), WIDTH));

    reduce_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .op    (op_q),
        .a     (acc_q),
        .b     (in_out_data),
        .y     (alu_y),
        .carry (alu_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_ADD;
            count_q <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            count_q <= count_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            valid_q <= (state_q == S_WRITE) && out_write_ready;
        end
    end

    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        count_d         = count_q;
        cnt_d           = cnt_q;
        acc_d           = acc_q;
        ovf_d           = ovf_q;
        in_read_valid   = 1'b0;
        out_write_valid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = reduce_op_t'(cfg_op);
                    count_d = count_clamp;
                    acc_d   = ident;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (count_clamp == '0) ? S_WRITE : S_READ;
                end
            end
            S_READ: begin
                // Pop strobe follows channel readiness directly: 1 word/cycle.
                in_read_valid = in_read_ready;
                if (in_read_ready) begin
                    acc_d = alu_y;
                    cnt_d = cnt_inc;
                    if (op_q == OP_ADD) ovf_d = ovf_q | alu_carry;
                    if (cnt_inc == count_q) state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                out_write_valid = 1'b1;
                if (out_write_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy        = (state_q != S_IDLE);
    assign valid       = valid_q;
    assign out_in_data = acc_q;
    assign result_ovf  = ovf_q && (state_q == S_WRITE);

    assign in_in_data     = '0;
    assign in_write_valid = 1'b0;
    assign in_rst         = 1'b0;
    assign out_read_valid = 1'b0;
    assign out_rst        = 1'b0;

    assign unused_ok = ^{in_write_ready, out_out_data, out_read_ready};

endmodule

// File: doc/channel_reduce_n.md
Name: channel_reduce_n

Overview:
- Parametrised successor to the fixed 4-element channel reducer.
- Pops a runtime-selected number of words from an input channel, folds them with a runtime-selected operator (add/max/min/xor), and pushes one result word to an output channel.
- Re-arms after each batch, so it serves repeated reductions in HLS-generated datapaths.
- Uses the standard channel port bundle, so it drops in wherever a channel consumer/producer sits.

Parameters:
WIDTH, 32, data width of both channels and the accumulator
MAX_COUNT, 16, largest batch length accepted on cfg_count
CW, $clog2(MAX_COUNT+1), width of cfg_count (derived; do not override)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a batch; sampled only in IDLE
cfg_count  in  CW  batch length, latched on accepted start
cfg_op  in  2  operator, latched on accepted start: 0 add (mod 2^WIDTH), 1 unsigned max, 2 unsigned min, 3 xor
busy  out  1  high from accepted start until the result handshake completes
valid  out  1  one-cycle pulse in the cycle after the result handshake
result_ovf  out  1  add mode only: unsigned carry-out occurred during the batch; valid alongside out_write_valid
in_out_data  in  WIDTH  input channel head word
in_read_ready  in  1  input channel non-empty
in_write_ready  in  1  unused
in_read_valid  out  1  pop strobe
in_in_data  out  WIDTH  tied 0
in_write_valid  out  1  tied 0
in_rst  out  1  tied 0
out_in_data  out  WIDTH  result word
out_write_valid  out  1  push strobe
out_write_ready  in  1  output channel has space
out_out_data  in  WIDTH  unused
out_read_ready  in  1  unused
out_read_valid  out  1  tied 0
out_rst  out  1  tied 0

Behaviour:
- Reset: state IDLE.
  - busy, valid, in_read_valid, out_write_valid, result_ovf all 0.
  - acc, cnt and the latched config cleared.
  - Reset mid-batch discards the partial result. No output word is produced and no further pops occur.
- States: IDLE, READ, WRITE.
- IDLE:
  - On start=1, latch cfg_count (values above MAX_COUNT clamp to MAX_COUNT) and cfg_op.
  - acc <= identity(op): add 0, max 0, min all-ones, xor 0. cnt <= 0, ovf <= 0.
  - If the latched count is 0, go to WRITE; otherwise go to READ.
- READ:
  - in_read_valid = in_read_ready, combinational. A pop occurs in any cycle where both are 1.
  - On a pop: acc <= op(acc, in_out_data); cnt <= cnt+1; ovf |= carry (add only).
  - On the pop where cnt == count-1, go to WRITE.
  - in_read_ready=0 stalls indefinitely with no state change.
  - Throughput: 1 word/cycle.
- WRITE:
  - out_write_valid = 1 and out_in_data = acc. Both hold stable until out_write_ready=1.
  - On handshake: go to IDLE, and valid pulses 1 in the next cycle.
- Latency: result presented in the cycle after the last pop. For a count=0 batch, result presented the cycle after start.
- start outside IDLE is ignored; no queuing.
- busy = (state != IDLE).
- Add is modulo 2^WIDTH; result_ovf reports any carry-out. result_ovf is 0 for all other ops.

Decomposition:
- Package channel_reduce_pkg holds:
  - the reduce_op_t enum (OP_ADD, OP_MAX, OP_MIN, OP_XOR);
  - the state enum;
  - an identity-value function parametrised by WIDTH.
- One combinational sub-module, reduce_alu(WIDTH): inputs op, a, b; outputs y, carry. Reused by future reduce blocks.

Test Plan:
- start, cfg_op=ADD, cfg_count=4; inputs 1,2,3,4 always ready -> exactly 4 pops on consecutive cycles, out_in_data=10, result_ovf=0, valid pulses once after handshake.
- ADD, count=2, WIDTH=32; inputs 0xFFFFFFFF,0x2 -> out_in_data=0x1, result_ovf=1.
- MAX then MIN back-to-back, count=3, inputs 5,9,2 each -> results 9 then 2; start asserted while busy ignored (no third result).
- XOR, count=0 -> zero pops, out_in_data=0 the cycle after start. MIN, count=0 -> out_in_data=0xFFFFFFFF.
- ADD, count=4, in_read_ready toggled 1/0 and out_write_ready held 0 for 5 cycles -> pops only on ready cycles, result held stable until ready, sum correct.
- rst asserted after 2 of 4 pops -> no push, all outputs 0. A new batch of count=1 with input 7 then yields 7.
